// File: rtl/resim_biriktirici.sv
`default_nettype none
// ============================================================================
//  Module      : resim_biriktirici
//  Description : Frame accumulator for filtered pixels. Pixels enter through a
//                small input FIFO. A three-state FSM drains the FIFO one pixel
//                per cycle and builds the frame sum and maximum. Once
//                PIKSEL_SAYISI pixels have been collected, it holds the result
//                until the consumer acknowledges it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PIKSEL_SAYISI    pixels per frame (2..64)
//    FIFO_DERINLIK    input FIFO depth in entries (power of two, >= 2)
//  Ports
//    clk              single clock, rising edge
//    rst              synchronous active-high reset
//    filtre_i         [4:0]  filtered pixel
//    filtre_gecerli_i        filtre_i valid this cycle
//    hazir_o                 FIFO can accept a pixel this cycle
//    sonuc_alindi_i          consumer acknowledges the frame result
//    toplam_o         [10:0] running / final frame sum
//    en_buyuk_o       [4:0]  running / final frame maximum
//    sonuc_gecerli_o         toplam_o / en_buyuk_o hold a completed frame
//    cerceve_sayisi_o [7:0]  count of acknowledged frames (wraps)
// ============================================================================
module resim_biriktirici #(
    parameter int PIKSEL_SAYISI = 8,
    parameter int FIFO_DERINLIK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  filtre_i,
    input  logic        filtre_gecerli_i,
    output logic        hazir_o,
    input  logic        sonuc_alindi_i,
    output logic [10:0] toplam_o,
    output logic [4:0]  en_buyuk_o,
    output logic        sonuc_gecerli_o,
    output logic [7:0]  cerceve_sayisi_o
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    // Pointer width: the depth is a power of two, so plain binary increment
    // of an AW-bit pointer wraps modulo FIFO_DERINLIK for free.
    localparam int AW = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;
    // Occupancy must represent the value FIFO_DERINLIK itself (full).
    localparam int OW = $clog2(FIFO_DERINLIK + 1);
    // Pixel counter must represent the value PIKSEL_SAYISI itself.
    localparam int CW = $clog2(PIKSEL_SAYISI + 1);

    localparam logic [OW-1:0] c_DERINLIK = OW'(FIFO_DERINLIK);
    localparam logic [CW-1:0] c_PIKSEL   = CW'(PIKSEL_SAYISI);

    // FSM encoding
    localparam logic [1:0] BOSTA = 2'd0;   // idle, waiting for a first pixel
    localparam logic [1:0] TOPLA = 2'd1;   // accumulating a frame
    localparam logic [1:0] SONUC = 2'd2;   // holding a completed frame

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]    durum_q,     durum_d;
    logic [4:0]    mem_q [FIFO_DERINLIK];
    logic [4:0]    mem_d [FIFO_DERINLIK];
    logic [AW-1:0] yaz_ptr_q,   yaz_ptr_d;
    logic [AW-1:0] oku_ptr_q,   oku_ptr_d;
    logic [OW-1:0] doluluk_q,   doluluk_d;
    logic [10:0]   toplam_q,    toplam_d;
    logic [4:0]    en_buyuk_q,  en_buyuk_d;
    logic [CW-1:0] sayac_q,     sayac_d;
    logic [7:0]    cerceve_q,   cerceve_d;

    // ------------------------------------------------------------------------
    // FIFO handshake
    // ------------------------------------------------------------------------
    logic       hazir;
    logic       push;
    logic       pop;
    logic [4:0] cekilen;        // pixel at the FIFO head

    // Ready depends only on registered occupancy, so there is no
    // combinational path from any input to hazir_o.
    assign hazir   = (doluluk_q < c_DERINLIK);
    assign push    = filtre_gecerli_i & hazir;
    // Pops happen in every state except SONUC, and only from a non-empty
    // FIFO. A pixel written this cycle is not yet counted in doluluk_q, so
    // it becomes poppable one cycle after its push.
    assign pop     = (durum_q != SONUC) && (doluluk_q != '0);
    assign cekilen = mem_q[oku_ptr_q];

    always_comb begin
        mem_d     = mem_q;
        yaz_ptr_d = yaz_ptr_q;
        oku_ptr_d = oku_ptr_q;
        doluluk_d = doluluk_q;

        if (push) begin
            mem_d[yaz_ptr_q] = filtre_i;
            yaz_ptr_d        = yaz_ptr_q + AW'(1);
        end
        if (pop) begin
            oku_ptr_d = oku_ptr_q + AW'(1);
        end

        // A simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   doluluk_d = doluluk_q + OW'(1);
            2'b01:   doluluk_d = doluluk_q - OW'(1);
            default: doluluk_d = doluluk_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Accumulator FSM
    // ------------------------------------------------------------------------
    always_comb begin
        durum_d    = durum_q;
        toplam_d   = toplam_q;
        en_buyuk_d = en_buyuk_q;
        sayac_d    = sayac_q;
        cerceve_d  = cerceve_q;

        case (durum_q)
            BOSTA: begin
                // The first pixel of a frame seeds sum and max directly.
                if (pop) begin
                    toplam_d   = {6'd0, cekilen};
                    en_buyuk_d = cekilen;
                    sayac_d    = CW'(1);
                    durum_d    = TOPLA;
                end
            end

            TOPLA: begin
                // With an empty FIFO, nothing is popped and all
                // accumulators simply hold.
                if (pop) begin
                    toplam_d = toplam_q + {6'd0, cekilen};
                    if (cekilen > en_buyuk_q) begin
                        en_buyuk_d = cekilen;
                    end
                    sayac_d = sayac_q + CW'(1);
                    if ((sayac_q + CW'(1)) == c_PIKSEL) begin
                        durum_d = SONUC;
                    end
                end
            end

            SONUC: begin
                // The acknowledge is only honoured here. It is ignored while
                // a frame is still being collected.
                if (sonuc_alindi_i) begin
                    toplam_d   = '0;
                    en_buyuk_d = '0;
                    sayac_d    = '0;
                    cerceve_d  = cerceve_q + 8'd1;
                    durum_d    = BOSTA;
                end
            end

            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers: reset takes priority over push, pop and acknowledge
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q    <= BOSTA;
            mem_q      <= '{default: '0};
            yaz_ptr_q  <= '0;
            oku_ptr_q  <= '0;
            doluluk_q  <= '0;
            toplam_q   <= '0;
            en_buyuk_q <= '0;
            sayac_q    <= '0;
            cerceve_q  <= '0;
        end else begin
            durum_q    <= durum_d;
            mem_q      <= mem_d;
            yaz_ptr_q  <= yaz_ptr_d;
            oku_ptr_q  <= oku_ptr_d;
            doluluk_q  <= doluluk_d;
            toplam_q   <= toplam_d;
            en_buyuk_q <= en_buyuk_d;
            sayac_q    <= sayac_d;
            cerceve_q  <= cerceve_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hazir_o          = hazir;
    assign toplam_o         = toplam_q;
    assign en_buyuk_o       = en_buyuk_q;
    assign sonuc_gecerli_o  = (durum_q == SONUC);
    assign cerceve_sayisi_o = cerceve_q;

endmodule
`default_nettype wire

// File: tb/tb_resim_biriktirici.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resim_biriktirici
//  Description : Self-checking bench for resim_biriktirici. A transaction
//                level reference model (pixel queue plus frame totals) runs
//                in lock-step with the DUT. It is driven by directed
//                scenarios followed by a long randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_resim_biriktirici;

    localparam int N = 8;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  filtre_i;
    logic        filtre_gecerli_i;
    logic        hazir_o;
    logic        sonuc_alindi_i;
    logic [10:0] toplam_o;
    logic [4:0]  en_buyuk_o;
    logic        sonuc_gecerli_o;
    logic [7:0]  cerceve_sayisi_o;

    always #5 clk = ~clk;

    resim_biriktirici #(
        .PIKSEL_SAYISI (N),
        .FIFO_DERINLIK (D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .filtre_i         (filtre_i),
        .filtre_gecerli_i (filtre_gecerli_i),
        .hazir_o          (hazir_o),
        .sonuc_alindi_i   (sonuc_alindi_i),
        .toplam_o         (toplam_o),
        .en_buyuk_o       (en_buyuk_o),
        .sonuc_gecerli_o  (sonuc_gecerli_o),
        .cerceve_sayisi_o (cerceve_sayisi_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: accepted pixels waiting in the buffer, the frame being
    // built, and whether a completed result is waiting for acknowledgement.
    int q[$];
    int m_sum;
    int m_max;
    int m_cnt;
    bit m_pending;
    int m_frames;
    int acks_done;
    bit saw_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("hazir", {31'd0, hazir_o}, (q.size() < D) ? 1 : 0);
        chk("sonuc_gecerli", {31'd0, sonuc_gecerli_o}, {31'd0, m_pending});
        chk("cerceve_sayisi", {24'd0, cerceve_sayisi_o}, m_frames);
        if (m_pending) begin
            chk("toplam", {21'd0, toplam_o}, m_sum);
            chk("en_buyuk", {27'd0, en_buyuk_o}, m_max);
        end
    endtask

    // One clock with the given inputs. The model advances at the edge and the
    // outputs are sampled 1 time unit later.
    task automatic step(input bit v, input int d, input bit a);
        bit accept;
        int p;
        rst              = 1'b0;
        filtre_gecerli_i = v;
        filtre_i         = 5'(d);
        sonuc_alindi_i   = a;
        accept = v && (q.size() < D);
        @(posedge clk);
        if (m_pending) begin
            if (a) begin
                m_pending = 1'b0;
                m_sum = 0;
                m_max = 0;
                m_cnt = 0;
                if (m_frames == 255) saw_wrap = 1'b1;
                m_frames = (m_frames + 1) % 256;
                acks_done++;
            end
        end else if (q.size() > 0) begin
            p = q.pop_front();
            m_sum += p;
            if (p > m_max) m_max = p;
            m_cnt++;
            if (m_cnt == N) m_pending = 1'b1;
        end
        if (accept) q.push_back(d);
        #1;
        check_outputs();
    endtask

    // Reset with push and acknowledge also asserted, to show reset priority.
    task automatic reset_pulse(input int cycles);
        rst              = 1'b1;
        filtre_gecerli_i = 1'b1;
        filtre_i         = 5'd17;
        sonuc_alindi_i   = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        q.delete();
        m_sum = 0;
        m_max = 0;
        m_cnt = 0;
        m_pending = 1'b0;
        m_frames = 0;
        check_outputs();
        chk("rst_toplam", {21'd0, toplam_o}, 0);
        chk("rst_en_buyuk", {27'd0, en_buyuk_o}, 0);
        rst = 1'b0;
    endtask

    initial begin
        int start_acks;
        int cyc;

        rst              = 1'b1;
        filtre_i         = '0;
        filtre_gecerli_i = 1'b0;
        sonuc_alindi_i   = 1'b0;
        acks_done        = 0;
        saw_wrap         = 1'b0;

        // Reset for two cycles
        reset_pulse(2);
        chk("rst_hazir_one", {31'd0, hazir_o}, 1);

        // Descending frame 31..24 back-to-back
        for (int i = 0; i < N; i++) step(1'b1, 31 - i, 1'b0);
        chk("desc_not_yet", {31'd0, sonuc_gecerli_o}, 0);
        step(1'b0, 0, 1'b0);
        chk("desc_valid", {31'd0, sonuc_gecerli_o}, 1);
        chk("desc_sum", {21'd0, toplam_o}, 220);
        chk("desc_max", {27'd0, en_buyuk_o}, 31);
        step(1'b0, 0, 1'b1);
        chk("desc_ack_cnt", {24'd0, cerceve_sayisi_o}, 1);
        chk("desc_ack_valid", {31'd0, sonuc_gecerli_o}, 0);

        // Fill the FIFO while a result is held
        for (int i = 0; i < N; i++) step(1'b1, i + 1, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("hold_valid", {31'd0, sonuc_gecerli_o}, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 10 + i, 1'b0);
            if (i == 3) chk("full_hazir", {31'd0, hazir_o}, 0);
        end
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0);
        repeat (3) step(1'b0, 0, 1'b0);
        chk("full_sum", {21'd0, toplam_o}, 54);
        chk("full_max", {27'd0, en_buyuk_o}, 13);
        step(1'b0, 0, 1'b1);

        // Alternating 0/5 with idle gaps
        for (int i = 0; i < N; i++) begin
            step(1'b1, (i % 2) * 5, 1'b0);
            repeat (3) step(1'b0, 0, 1'b0);
        end
        chk("gap_sum", {21'd0, toplam_o}, 20);
        chk("gap_max", {27'd0, en_buyuk_o}, 5);
        step(1'b0, 0, 1'b1);

        // Reset mid-frame discards buffered and partial data
        for (int i = 0; i < 3; i++) step(1'b1, 7, 1'b0);
        reset_pulse(1);
        for (int i = 0; i < N; i++) step(1'b1, 1, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("mid_rst_sum", {21'd0, toplam_o}, 8);
        chk("mid_rst_cnt", {24'd0, cerceve_sayisi_o}, 0);
        step(1'b0, 0, 1'b1);
        chk("mid_rst_ack", {24'd0, cerceve_sayisi_o}, 1);

        // Acknowledge while idle or accumulating has no effect
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 4, 1'b0);
        step(1'b0, 0, 1'b1);
        chk("ign_ack_valid", {31'd0, sonuc_gecerli_o}, 1);
        chk("ign_ack_sum", {21'd0, toplam_o}, 32);
        step(1'b0, 0, 1'b1);

        // Randomized traffic through the 255 -> 0 frame counter wrap
        start_acks = acks_done;
        cyc = 0;
        while ((acks_done - start_acks) < 260 && cyc < 20000) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                 ($urandom_range(0, 2) == 0));
            cyc++;
        end
        chk("random_budget", ((acks_done - start_acks) >= 260) ? 1 : 0, 1);
        chk("wrap_seen", {31'd0, saw_wrap}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
